// File: rtl/evr_pulse_bank_if.sv
// Signal bundle between the event mapping RAM / register set and the pulse bank.
// Fields are flat-packed per channel: channel c sits at [c*CNT_W +: CNT_W].
interface evr_pulse_bank_if #(
    parameter int NCH   = 14,
    parameter int CNT_W = 32
);
    logic [NCH-1:0]       trig_i;
    logic [NCH-1:0]       set_i;
    logic [NCH-1:0]       clr_i;
    logic [NCH-1:0]       enable_i;
    logic [NCH-1:0]       polarity_i;
    logic [NCH-1:0]       retrig_i;
    logic [NCH*CNT_W-1:0] delay_i;
    logic [NCH*CNT_W-1:0] width_i;
    logic                 ovr_clr_i;
    logic [NCH-1:0]       pulse_o;
    logic [NCH-1:0]       busy_o;
    logic [NCH-1:0]       overrun_o;

    modport master (
        output trig_i, set_i, clr_i, enable_i, polarity_i, retrig_i,
        output delay_i, width_i, ovr_clr_i,
        input  pulse_o, busy_o, overrun_o
    );

    modport slave (
        input  trig_i, set_i, clr_i, enable_i, polarity_i, retrig_i,
        input  delay_i, width_i, ovr_clr_i,
        output pulse_o, busy_o, overrun_o
    );
endinterface

// File: rtl/evr_pulse_bank.sv
// N-channel delayed pulse generator with set/clear level latch, retrigger
// control and sticky overrun flags; every output is one register behind the FSM.
module evr_pulse_bank #(
    parameter int NCH   = 14,
    parameter int CNT_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_n,
    evr_pulse_bank_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t           state_q [NCH];
    state_t           state_d [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];
    logic [CNT_W-1:0] wid_q   [NCH];
    logic [CNT_W-1:0] wid_d   [NCH];
    logic [CNT_W-1:0] dly_in  [NCH];
    logic [CNT_W-1:0] wid_in  [NCH];

    logic [NCH-1:0] latch_q, latch_d;
    logic [NCH-1:0] ovr_q, ovr_d;
    logic [NCH-1:0] ovr_evt;
    logic [NCH-1:0] pulse_q, pulse_d;
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] ovr_out_q;

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign dly_in[g] = bus.delay_i[g*CNT_W +: CNT_W];
        assign wid_in[g] = bus.width_i[g*CNT_W +: CNT_W];
    end

    always_comb begin
        // NOTE: every comb output gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        ovr_evt = '0;
        latch_d = latch_q;
        pulse_d = '0;
        busy_d  = '0;
        for (int c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            wid_d[c]   = wid_q[c];

            unique case (state_q[c])
                ST_DELAY: begin
                    if (cnt_q[c] != '0) begin
                        cnt_d[c] = cnt_q[c] - 1'b1;
                    end else if (wid_q[c] == '0) begin
                        state_d[c] = ST_IDLE;
                    end else begin
                        state_d[c] = ST_ACTIVE;
                        cnt_d[c]   = wid_q[c] - 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q[c] != '0) cnt_d[c]   = cnt_q[c] - 1'b1;
                    else                state_d[c] = ST_IDLE;
                end
                default: ;
            endcase

            // Clear beats everything, including a disabled channel's held latch.
            if (bus.clr_i[c]) begin
                state_d[c] = ST_IDLE;
                cnt_d[c]   = '0;
                latch_d[c] = 1'b0;
            end else if (!bus.enable_i[c]) begin
                state_d[c] = ST_IDLE;
                cnt_d[c]   = '0;
            end else begin
                if (bus.set_i[c]) latch_d[c] = 1'b1;
                if (bus.trig_i[c]) begin
                    if (state_q[c] == ST_IDLE || bus.retrig_i[c]) begin
                        wid_d[c] = wid_in[c];
                        if (dly_in[c] != '0) begin
                            state_d[c] = ST_DELAY;
                            cnt_d[c]   = dly_in[c] - 1'b1;
                        end else if (wid_in[c] != '0) begin
                            state_d[c] = ST_ACTIVE;
                            cnt_d[c]   = wid_in[c] - 1'b1;
                        end else begin
                            state_d[c] = ST_IDLE;
                            cnt_d[c]   = '0;
                        end
                    end else begin
                        ovr_evt[c] = 1'b1;
                    end
                end
            end

            pulse_d[c] = bus.enable_i[c]
                       ? (((state_q[c] == ST_ACTIVE) | latch_q[c]) ^ bus.polarity_i[c])
                       : bus.polarity_i[c];
            busy_d[c]  = (state_q[c] != ST_IDLE);
        end
        // A new overrun in the clearing cycle keeps the flag set.
        ovr_d = (ovr_q & ~{NCH{bus.ovr_clr_i}}) | ovr_evt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= '0;
                wid_q[c]   <= '0;
            end
            latch_q   <= '0;
            ovr_q     <= '0;
            pulse_q   <= '0;
            busy_q    <= '0;
            ovr_out_q <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                wid_q[c]   <= wid_d[c];
            end
            latch_q   <= latch_d;
            ovr_q     <= ovr_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            ovr_out_q <= ovr_q;
        end
    end

    assign bus.pulse_o   = pulse_q;
    assign bus.busy_o    = busy_q;
    assign bus.overrun_o = ovr_out_q;

endmodule

// File: tb/tb_evr_pulse_bank.sv
// Bench for evr_pulse_bank: directed scenarios plus a randomized run checked
// against a time-window model of each channel's trigger/latch/overrun rules.
module tb_evr_pulse_bank;

    localparam int NCH   = 14;
    localparam int CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    evr_pulse_bank_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    evr_pulse_bank #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    longint cyc = 0;

    // Model: each channel remembers its last accepted trigger edge k with the
    // captured D and W; it is busy on edges [k, k+D+W) and active on [k+D, k+D+W).
    bit             m_valid [NCH];
    longint         m_k     [NCH];
    longint         m_d     [NCH];
    longint         m_w     [NCH];
    logic [NCH-1:0] m_l, m_ovr, m_pulse, m_busy, m_ovr_o;

    function automatic bit m_running(int c, longint t);
        return m_valid[c] && t >= m_k[c] && t < m_k[c] + m_d[c] + m_w[c];
    endfunction

    function automatic bit m_active(int c, longint t);
        return m_valid[c] && t >= m_k[c] + m_d[c] && t < m_k[c] + m_d[c] + m_w[c];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) m_valid[c] = 1'b0;
        m_l = '0; m_ovr = '0; m_pulse = '0; m_busy = '0; m_ovr_o = '0;
    endtask

    task automatic model_edge(longint n);
        bit run, act, en, pol, hit;
        for (int c = 0; c < NCH; c++) begin
            run = m_running(c, n - 1);
            act = m_active(c, n - 1);
            en  = bus.enable_i[c];
            pol = bus.polarity_i[c];
            m_pulse[c] = en ? ((act | m_l[c]) ^ pol) : pol;
            m_busy[c]  = run;
            m_ovr_o[c] = m_ovr[c];
            hit = 1'b0;
            if (bus.clr_i[c]) begin
                m_valid[c] = 1'b0;
                m_l[c]     = 1'b0;
            end else if (!en) begin
                m_valid[c] = 1'b0;
            end else begin
                if (bus.set_i[c]) m_l[c] = 1'b1;
                if (bus.trig_i[c]) begin
                    if (!run || bus.retrig_i[c]) begin
                        m_valid[c] = 1'b1;
                        m_k[c] = n;
                        m_d[c] = longint'(bus.delay_i[c*CNT_W +: CNT_W]);
                        m_w[c] = longint'(bus.width_i[c*CNT_W +: CNT_W]);
                    end else begin
                        hit = 1'b1;
                    end
                end
            end
            m_ovr[c] = (m_ovr[c] & ~bus.ovr_clr_i) | hit;
        end
    endtask

    // One rising edge; inputs were driven away from the edge, outputs are read 1 ns after.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else        model_edge(cyc);
        #1;
    endtask

    task automatic set_dw(input int c, input int d, input int w);
        bus.delay_i[c*CNT_W +: CNT_W] = CNT_W'(d);
        bus.width_i[c*CNT_W +: CNT_W] = CNT_W'(w);
    endtask

    task automatic clear_strobes();
        bus.trig_i = '0; bus.set_i = '0; bus.clr_i = '0; bus.ovr_clr_i = 1'b0;
    endtask

    // Only channel 0 enabled, positive polarity, no retrigger.
    task automatic solo_cfg();
        clear_strobes();
        bus.enable_i   = NCH'(1);
        bus.polarity_i = '0;
        bus.retrig_i   = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        clear_strobes();
        bus.enable_i = '1; bus.polarity_i = '1; bus.retrig_i = '0;
        bus.delay_i = '0; bus.width_i = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        n_cmp++; if (bus.pulse_o !== '0)   begin n_err++; $display("FAIL reset_pulse: got %h expected %h", bus.pulse_o, {NCH{1'b0}}); end
        n_cmp++; if (bus.busy_o !== '0)    begin n_err++; $display("FAIL reset_busy: got %h expected %h", bus.busy_o, {NCH{1'b0}}); end
        n_cmp++; if (bus.overrun_o !== '0) begin n_err++; $display("FAIL reset_overrun: got %h expected %h", bus.overrun_o, {NCH{1'b0}}); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.pulse_o !== {NCH{1'b1}}) begin n_err++; $display("FAIL reset_release_polarity: got %h expected %h", bus.pulse_o, {NCH{1'b1}}); end
    endtask

    task automatic test_single_shot();
        solo_cfg();
        set_dw(0, 3, 4);
        for (int t = 0; t <= 12; t++) begin
            bus.trig_i[0] = (t == 0);
            tick();
            if (t >= 1) begin
                n_cmp++; if (bus.pulse_o[0] !== (t >= 4 && t <= 7)) begin n_err++; $display("FAIL single_pulse t=%0d: got %b expected %b", t, bus.pulse_o[0], (t >= 4 && t <= 7)); end
                n_cmp++; if (bus.busy_o[0] !== (t >= 1 && t <= 7))  begin n_err++; $display("FAIL single_busy t=%0d: got %b expected %b", t, bus.busy_o[0], (t >= 1 && t <= 7)); end
            end
        end
        clear_strobes();
    endtask

    task automatic test_zero();
        solo_cfg();
        set_dw(0, 0, 1);
        for (int t = 0; t <= 5; t++) begin
            bus.trig_i[0] = (t == 0);
            tick();
            if (t >= 1) begin
                n_cmp++; if (bus.pulse_o[0] !== (t == 1)) begin n_err++; $display("FAIL d0w1_pulse t=%0d: got %b expected %b", t, bus.pulse_o[0], (t == 1)); end
                n_cmp++; if (bus.busy_o[0] !== (t == 1))  begin n_err++; $display("FAIL d0w1_busy t=%0d: got %b expected %b", t, bus.busy_o[0], (t == 1)); end
            end
        end
        set_dw(0, 2, 0);
        for (int t = 0; t <= 6; t++) begin
            bus.trig_i[0] = (t == 0);
            tick();
            if (t >= 1) begin
                n_cmp++; if (bus.pulse_o[0] !== 1'b0) begin n_err++; $display("FAIL d2w0_pulse t=%0d: got %b expected 0", t, bus.pulse_o[0]); end
                n_cmp++; if (bus.busy_o[0] !== (t == 1 || t == 2)) begin n_err++; $display("FAIL d2w0_busy t=%0d: got %b expected %b", t, bus.busy_o[0], (t == 1 || t == 2)); end
            end
        end
        clear_strobes();
    endtask

    task automatic test_retrigger();
        bit exp;
        solo_cfg();
        bus.retrig_i[0] = 1'b1;
        set_dw(0, 2, 10);
        for (int t = 0; t <= 22; t++) begin
            bus.trig_i[0] = (t == 0 || t == 6);
            tick();
            exp = (t >= 3 && t <= 6) || (t >= 9 && t <= 18);
            if (t >= 1) begin
                n_cmp++; if (bus.pulse_o[0] !== exp) begin n_err++; $display("FAIL retrig_pulse t=%0d: got %b expected %b", t, bus.pulse_o[0], exp); end
            end
        end
        solo_cfg();
        set_dw(0, 2, 10);
        for (int t = 0; t <= 20; t++) begin
            bus.trig_i[0]  = (t == 0 || t == 6 || t == 11);
            bus.ovr_clr_i  = (t == 11 || t == 15);
            tick();
            if (t >= 1) begin
                n_cmp++; if (bus.pulse_o[0] !== (t >= 3 && t <= 12))   begin n_err++; $display("FAIL noretrig_pulse t=%0d: got %b expected %b", t, bus.pulse_o[0], (t >= 3 && t <= 12)); end
                n_cmp++; if (bus.overrun_o[0] !== (t >= 7 && t <= 15)) begin n_err++; $display("FAIL noretrig_overrun t=%0d: got %b expected %b", t, bus.overrun_o[0], (t >= 7 && t <= 15)); end
            end
        end
        clear_strobes();
    endtask

    task automatic test_set_clr();
        bit exp;
        solo_cfg();
        set_dw(0, 0, 8);
        for (int t = 0; t <= 40; t++) begin
            bus.set_i[0]  = (t == 0 || t == 25);
            bus.clr_i[0]  = (t == 20 || t == 25 || t == 33);
            bus.trig_i[0] = (t == 30);
            tick();
            exp = (t >= 1 && t <= 20) || (t >= 31 && t <= 33);
            if (t >= 1) begin
                n_cmp++; if (bus.pulse_o[0] !== exp) begin n_err++; $display("FAIL setclr_pulse t=%0d: got %b expected %b", t, bus.pulse_o[0], exp); end
                n_cmp++; if (bus.busy_o[0] !== (t >= 31 && t <= 33)) begin n_err++; $display("FAIL setclr_busy t=%0d: got %b expected %b", t, bus.busy_o[0], (t >= 31 && t <= 33)); end
            end
        end
        clear_strobes();
    endtask

    task automatic test_pol_enable();
        solo_cfg();
        bus.enable_i[0]   = 1'b0;
        bus.polarity_i[0] = 1'b1;
        set_dw(0, 0, 3);
        for (int t = 0; t <= 8; t++) begin
            bus.trig_i[0] = (t == 0 || t == 2);
            tick();
            if (t >= 1) begin
                n_cmp++; if (bus.pulse_o[0] !== 1'b1)   begin n_err++; $display("FAIL disabled_pulse t=%0d: got %b expected 1", t, bus.pulse_o[0]); end
                n_cmp++; if (bus.busy_o[0] !== 1'b0)    begin n_err++; $display("FAIL disabled_busy t=%0d: got %b expected 0", t, bus.busy_o[0]); end
                n_cmp++; if (bus.overrun_o[0] !== 1'b0) begin n_err++; $display("FAIL disabled_overrun t=%0d: got %b expected 0", t, bus.overrun_o[0]); end
            end
        end
        clear_strobes();
    endtask

    task automatic test_multichannel();
        logic [NCH-1:0] exp;
        clear_strobes();
        bus.enable_i = '1; bus.polarity_i = '0; bus.retrig_i = '0;
        for (int c = 0; c < NCH; c++) set_dw(c, c, c + 1);
        repeat (2) tick();
        for (int t = 0; t <= 30; t++) begin
            bus.trig_i = (t == 0) ? {NCH{1'b1}} : {NCH{1'b0}};
            tick();
            for (int c = 0; c < NCH; c++) exp[c] = (t >= c + 1 && t <= 2 * c + 1);
            if (t >= 1) begin
                n_cmp++; if (bus.pulse_o !== exp) begin n_err++; $display("FAIL multi_pulse t=%0d: got %h expected %h", t, bus.pulse_o, exp); end
            end
        end
        clear_strobes();
    endtask

    task automatic test_random();
        logic [NCH-1:0] en_v;
        en_v = '1;
        bus.polarity_i = '0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(39) == 0) en_v[c] = ~en_v[c];
                if ($urandom_range(59) == 0) bus.polarity_i[c] = ~bus.polarity_i[c];
                bus.trig_i[c]   = ($urandom_range(5) == 0);
                bus.set_i[c]    = ($urandom_range(24) == 0);
                bus.clr_i[c]    = ($urandom_range(24) == 0);
                bus.retrig_i[c] = ($urandom_range(1) == 0);
                set_dw(c, int'($urandom_range(5)), int'($urandom_range(5)));
            end
            bus.enable_i  = en_v;
            bus.ovr_clr_i = ($urandom_range(9) == 0);
            tick();
            n_cmp++; if (bus.pulse_o !== m_pulse)   begin n_err++; $display("FAIL rand_pulse i=%0d: got %h expected %h", i, bus.pulse_o, m_pulse); end
            n_cmp++; if (bus.busy_o !== m_busy)     begin n_err++; $display("FAIL rand_busy i=%0d: got %h expected %h", i, bus.busy_o, m_busy); end
            n_cmp++; if (bus.overrun_o !== m_ovr_o) begin n_err++; $display("FAIL rand_overrun i=%0d: got %h expected %h", i, bus.overrun_o, m_ovr_o); end
        end
        clear_strobes();
    endtask

    task automatic test_async_reset();
        solo_cfg();
        bus.enable_i[1]   = 1'b1;
        bus.polarity_i[1] = 1'b1;
        set_dw(0, 0, 20);
        for (int t = 0; t <= 6; t++) begin
            bus.trig_i[0] = (t == 0 || t == 3);
            tick();
        end
        clear_strobes();
        n_cmp++; if (bus.overrun_o[0] !== 1'b1) begin n_err++; $display("FAIL prereset_overrun: got %b expected 1", bus.overrun_o[0]); end
        n_cmp++; if (bus.pulse_o[0] !== 1'b1)   begin n_err++; $display("FAIL prereset_pulse: got %b expected 1", bus.pulse_o[0]); end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus.pulse_o !== '0)   begin n_err++; $display("FAIL async_pulse: got %h expected %h", bus.pulse_o, {NCH{1'b0}}); end
        n_cmp++; if (bus.busy_o !== '0)    begin n_err++; $display("FAIL async_busy: got %h expected %h", bus.busy_o, {NCH{1'b0}}); end
        n_cmp++; if (bus.overrun_o !== '0) begin n_err++; $display("FAIL async_overrun: got %h expected %h", bus.overrun_o, {NCH{1'b0}}); end
        repeat (2) tick();
        n_cmp++; if (bus.pulse_o !== '0) begin n_err++; $display("FAIL held_reset_pulse: got %h expected %h", bus.pulse_o, {NCH{1'b0}}); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.pulse_o !== m_pulse) begin n_err++; $display("FAIL post_reset_pulse: got %h expected %h", bus.pulse_o, m_pulse); end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_zero();
        test_retrigger();
        test_set_clr();
        test_pol_enable();
        test_multichannel();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
